// File: rtl/axis_uart_pkg.sv
// ============================================================================
// Module : axis_uart_pkg
// Brief  : Shared defaults, beat type and width helper for the AXIS-to-UART path
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

package axis_uart_pkg;

    localparam int AXIS_WIDTH_DEF = 8;
    localparam int AXIS_DEPTH_DEF = 16;

    typedef struct packed {
        logic                      last;
        logic [AXIS_WIDTH_DEF-1:0] data;
    } axis_beat_t;

    // Width of a pointer or level that must represent 0..n inclusive
    function automatic int clog2p1(input int n);
        return $clog2(n) + 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/axis_sync_fifo.sv
// ============================================================================
// Module : axis_sync_fifo
// Brief  : Synchronous {last,data} storage with extra-MSB pointers and level
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module axis_sync_fifo
    import axis_uart_pkg::*;
#(
    parameter int WIDTH = AXIS_WIDTH_DEF,
    parameter int DEPTH = AXIS_DEPTH_DEF
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        clr,
    input  logic                        wr_en,
    input  logic [WIDTH:0]              wr_data,
    input  logic                        rd_en,
    output logic [WIDTH:0]              rd_data,
    output logic                        full,
    output logic                        empty,
    output logic [clog2p1(DEPTH)-1:0]   level
);

    localparam int LW = clog2p1(DEPTH);
    localparam int AW = LW - 1;

    logic [WIDTH:0]  mem [DEPTH];
    logic [LW-1:0]   wr_ptr;
    logic [LW-1:0]   rd_ptr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + LW'(1);
            if (rd_en) rd_ptr <= rd_ptr + LW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

    // Extra pointer MSB distinguishes full from empty when the indices match
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty   = (wr_ptr == rd_ptr);
    assign level   = wr_ptr - rd_ptr;
    assign rd_data = mem[rd_ptr[AW-1:0]];

endmodule

`default_nettype wire

// File: rtl/axis_master_fifo.sv
// ============================================================================
// Module : axis_master_fifo
// Brief  : Buffered AXI-Stream master with registered output, packet counter
//          and flush. Define AXIS_STORE_FWD_EN for store-and-forward release.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module axis_master_fifo
    import axis_uart_pkg::*;
#(
    parameter int WIDTH = AXIS_WIDTH_DEF,
    parameter int DEPTH = AXIS_DEPTH_DEF,
    parameter int CNT_W = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        flush,
    input  logic [WIDTH-1:0]            load_data,
    input  logic                        load_last,
    input  logic                        load_valid,
    output logic                        load_ready,
    output logic [WIDTH-1:0]            m_axis_data,
    output logic                        m_axis_last,
    output logic                        m_axis_valid,
    input  logic                        m_axis_ready,
    output logic [clog2p1(DEPTH)-1:0]   level,
    output logic [CNT_W-1:0]            pkt_count
);

    localparam int LW = clog2p1(DEPTH);

    logic [WIDTH:0] rd_beat;
    logic           full;
    logic           empty;
    logic           wr_en;
    logic           pop;
    logic           pop_gate;
    logic           handshake;

    assign load_ready = !rst && !full;
    assign wr_en      = load_valid && load_ready && !flush;
    assign handshake  = m_axis_valid && m_axis_ready;

    axis_sync_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_store (
        .clk     (clk),
        .rst     (rst),
        .clr     (flush),
        .wr_en   (wr_en),
        .wr_data ({load_last, load_data}),
        .rd_en   (pop),
        .rd_data (rd_beat),
        .full    (full),
        .empty   (empty),
        .level   (level)
    );

`ifdef AXIS_STORE_FWD_EN
    logic [LW-1:0] pkts_stored;
    logic          pkt_in;
    logic          pkt_out;

    assign pkt_in  = wr_en && load_last;
    assign pkt_out = pop && rd_beat[WIDTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pkts_stored <= '0;
        end else if (flush) begin
            pkts_stored <= '0;
        end else if (pkt_in && !pkt_out) begin
            pkts_stored <= pkts_stored + LW'(1);
        end else if (pkt_out && !pkt_in) begin
            pkts_stored <= pkts_stored - LW'(1);
        end
    end

    // Full storage releases anyway so packets longer than DEPTH cannot deadlock
    assign pop_gate = (pkts_stored != '0) || full;
`else
    assign pop_gate = 1'b1;
`endif

    assign pop = !flush && !empty && pop_gate && (!m_axis_valid || m_axis_ready);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_axis_valid <= 1'b0;
            m_axis_last  <= 1'b0;
            m_axis_data  <= '0;
        end else if (flush) begin
            m_axis_valid <= 1'b0;
            m_axis_last  <= 1'b0;
        end else if (pop) begin
            m_axis_valid <= 1'b1;
            m_axis_last  <= rd_beat[WIDTH];
            m_axis_data  <= rd_beat[WIDTH-1:0];
        end else if (handshake) begin
            m_axis_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pkt_count <= '0;
        end else if (!flush && handshake && m_axis_last) begin
            pkt_count <= pkt_count + CNT_W'(1);
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_axis_master_fifo.sv
// ============================================================================
// Module : tb_axis_master_fifo
// Brief  : Directed vector table plus hand sequences for axis_master_fifo
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_axis_master_fifo;
    import axis_uart_pkg::*;

    localparam int WIDTH = 8;
    localparam int DEPTH = 16;
    localparam int CNT_W = 16;
    localparam int LW    = clog2p1(DEPTH);

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             flush = 1'b0;
    logic [WIDTH-1:0] load_data = '0;
    logic             load_last = 1'b0;
    logic             load_valid = 1'b0;
    logic             load_ready;
    logic [WIDTH-1:0] m_axis_data;
    logic             m_axis_last;
    logic             m_axis_valid;
    logic             m_axis_ready = 1'b0;
    logic [LW-1:0]    level;
    logic [CNT_W-1:0] pkt_count;

    int nvec = 0;
    int nmis = 0;

    axis_master_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .load_data    (load_data),
        .load_last    (load_last),
        .load_valid   (load_valid),
        .load_ready   (load_ready),
        .m_axis_data  (m_axis_data),
        .m_axis_last  (m_axis_last),
        .m_axis_valid (m_axis_valid),
        .m_axis_ready (m_axis_ready),
        .level        (level),
        .pkt_count    (pkt_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] d;
        logic       l;
        logic       v;
        logic       rdy;
        logic       ev;
        logic [7:0] ed;
        logic       el;
        int         elev;
        int         epkt;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic [7:0] d, input logic l, v, rdy, ev,
                                input logic [7:0] ed, input logic el, input int elev, epkt);
        vec_t r;
        r.d = d; r.l = l; r.v = v; r.rdy = rdy;
        r.ev = ev; r.ed = ed; r.el = el; r.elev = elev; r.epkt = epkt;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one byte and hold it until accepted, bounded
    task automatic push(input logic [7:0] d, input logic l);
        bit done;
        done = 0;
        load_data  = d;
        load_last  = l;
        load_valid = 1'b1;
        for (int i = 0; i < 64 && !done; i++) begin
            if (load_ready) done = 1;
            step();
        end
        if (!done) check("push.timeout", 0, 1);
        load_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [8:0] q[$];
        logic [8:0] e;
        int         sent, got;
        bit         hold;
        logic [7:0] hd;
        logic       hl;

        // Reset state while rst is held
        #1;
        check("rst.valid", m_axis_valid, 0);
        check("rst.level", level, 0);
        check("rst.pkt", pkt_count, 0);
        check("rst.load_ready", load_ready, 0);
        check("rst.data", m_axis_data, 0);
        step();
        step();
        rst = 1'b0;
        #1;
        check("rel.load_ready", load_ready, 1);

        // "HELLO\n" with continuous ready
`ifdef AXIS_STORE_FWD_EN
        tbl.push_back(mk(8'h48, 0, 1, 1, 0, 8'h00, 0, 1, 0));
        tbl.push_back(mk(8'h45, 0, 1, 1, 0, 8'h00, 0, 2, 0));
        tbl.push_back(mk(8'h4C, 0, 1, 1, 0, 8'h00, 0, 3, 0));
        tbl.push_back(mk(8'h4C, 0, 1, 1, 0, 8'h00, 0, 4, 0));
        tbl.push_back(mk(8'h4F, 0, 1, 1, 0, 8'h00, 0, 5, 0));
        tbl.push_back(mk(8'h0A, 1, 1, 1, 0, 8'h00, 0, 6, 0));
        tbl.push_back(mk(8'h00, 0, 0, 1, 1, 8'h48, 0, 5, 0));
        tbl.push_back(mk(8'h00, 0, 0, 1, 1, 8'h45, 0, 4, 0));
        tbl.push_back(mk(8'h00, 0, 0, 1, 1, 8'h4C, 0, 3, 0));
        tbl.push_back(mk(8'h00, 0, 0, 1, 1, 8'h4C, 0, 2, 0));
        tbl.push_back(mk(8'h00, 0, 0, 1, 1, 8'h4F, 0, 1, 0));
        tbl.push_back(mk(8'h00, 0, 0, 1, 1, 8'h0A, 1, 0, 0));
        tbl.push_back(mk(8'h00, 0, 0, 1, 0, 8'h00, 0, 0, 1));
`else
        tbl.push_back(mk(8'h48, 0, 1, 1, 0, 8'h00, 0, 1, 0));
        tbl.push_back(mk(8'h45, 0, 1, 1, 1, 8'h48, 0, 1, 0));
        tbl.push_back(mk(8'h4C, 0, 1, 1, 1, 8'h45, 0, 1, 0));
        tbl.push_back(mk(8'h4C, 0, 1, 1, 1, 8'h4C, 0, 1, 0));
        tbl.push_back(mk(8'h4F, 0, 1, 1, 1, 8'h4C, 0, 1, 0));
        tbl.push_back(mk(8'h0A, 1, 1, 1, 1, 8'h4F, 0, 1, 0));
        tbl.push_back(mk(8'h00, 0, 0, 1, 1, 8'h0A, 1, 0, 0));
        tbl.push_back(mk(8'h00, 0, 0, 1, 0, 8'h00, 0, 0, 1));
`endif
        foreach (tbl[i]) begin
            load_data    = tbl[i].d;
            load_last    = tbl[i].l;
            load_valid   = tbl[i].v;
            m_axis_ready = tbl[i].rdy;
            step();
            check($sformatf("v%0d.valid", i), m_axis_valid, tbl[i].ev);
            if (tbl[i].ev) begin
                check($sformatf("v%0d.data", i), m_axis_data, tbl[i].ed);
                check($sformatf("v%0d.last", i), m_axis_last, tbl[i].el);
            end
            check($sformatf("v%0d.level", i), level, tbl[i].elev);
            check($sformatf("v%0d.pkt", i), pkt_count, tbl[i].epkt);
        end
        load_valid = 1'b0;

        // Reset mid-stream
        m_axis_ready = 1'b0;
        push(8'h41, 0);
        push(8'h42, 0);
        rst = 1'b1;
        #1;
        check("mid.valid", m_axis_valid, 0);
        check("mid.level", level, 0);
        check("mid.pkt", pkt_count, 0);
        check("mid.load_ready", load_ready, 0);
        step();
        rst = 1'b0;
        #1;
        check("mid.rel_ready", load_ready, 1);
        check("mid.rel_data", m_axis_data, 0);

        // Backpressure to full: 17 bytes fill storage plus the output register
        for (int i = 0; i <= 16; i++) push(8'(i), i == 16);
        load_data  = 8'h11;
        load_last  = 1'b0;
        load_valid = 1'b1;
        check("full.load_ready", load_ready, 0);
        step();
        load_valid = 1'b0;
        check("full.level", level, 16);
        check("full.load_ready2", load_ready, 0);
        check("full.valid", m_axis_valid, 1);
        check("full.data", m_axis_data, 0);
        m_axis_ready = 1'b1;
        got = 0;
        for (int c = 0; c < 100 && got < 17; c++) begin
            if (m_axis_valid) begin
                check("drain.data", m_axis_data, got);
                check("drain.last", m_axis_last, (got == 16));
                got++;
            end
            step();
        end
        check("drain.count", got, 17);
        check("drain.pkt", pkt_count, 1);
        check("drain.level", level, 0);

        // Flush with five bytes queued; the byte offered alongside flush is dropped
        m_axis_ready = 1'b0;
        for (int i = 0; i < 5; i++) push(8'hA0 + 8'(i), 0);
        flush      = 1'b1;
        load_data  = 8'h99;
        load_last  = 1'b1;
        load_valid = 1'b1;
        step();
        flush      = 1'b0;
        load_valid = 1'b0;
        check("flush.valid", m_axis_valid, 0);
        check("flush.level", level, 0);
        check("flush.pkt", pkt_count, 1);
        push(8'h55, 1);
        m_axis_ready = 1'b1;
        for (int c = 0; c < 10 && !m_axis_valid; c++) step();
        check("flush.first_valid", m_axis_valid, 1);
        check("flush.first_data", m_axis_data, 8'h55);
        check("flush.first_last", m_axis_last, 1);
        step();
        check("flush.pkt2", pkt_count, 2);
        step();
        check("flush.empty_valid", m_axis_valid, 0);
        check("flush.empty_level", level, 0);

        // Random stalls: scoreboard ordering and hold-while-stalled
        sent = 0;
        got  = 0;
        hold = 0;
        for (int c = 0; c < 3000 && got < 100; c++) begin
            m_axis_ready = 1'($urandom_range(0, 1));
            load_valid   = (sent < 100) && ($urandom_range(0, 3) != 0);
            load_data    = 8'(sent * 7 + 3);
            load_last    = (sent % 10 == 9);
            if (m_axis_valid && m_axis_ready) begin
                if (q.size() == 0) begin
                    check("rnd.spurious", 1, 0);
                end else begin
                    e = q.pop_front();
                    check("rnd.data", m_axis_data, e[7:0]);
                    check("rnd.last", m_axis_last, e[8]);
                end
                got++;
            end
            if (load_valid && load_ready) begin
                q.push_back({load_last, load_data});
                sent++;
            end
            hold = m_axis_valid && !m_axis_ready;
            hd   = m_axis_data;
            hl   = m_axis_last;
            step();
            if (hold) begin
                check("rnd.hold_valid", m_axis_valid, 1);
                check("rnd.hold_data", m_axis_data, hd);
                check("rnd.hold_last", m_axis_last, hl);
            end
        end
        load_valid = 1'b0;
        check("rnd.count", got, 100);
        check("rnd.pkt", pkt_count, 12);

`ifdef AXIS_STORE_FWD_EN
        // Incomplete packet is held back until its last byte arrives
        m_axis_ready = 1'b1;
        push(8'h61, 0);
        push(8'h62, 0);
        push(8'h63, 0);
        step();
        step();
        check("sf.hold_valid", m_axis_valid, 0);
        check("sf.hold_level", level, 3);
        push(8'h64, 1);
        got = 0;
        for (int c = 0; c < 20 && got < 4; c++) begin
            if (m_axis_valid) begin
                check("sf.data", m_axis_data, 8'h61 + got);
                check("sf.last", m_axis_last, (got == 3));
                got++;
            end
            step();
        end
        check("sf.count", got, 4);
        check("sf.pkt", pkt_count, 13);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/axis_master_fifo.md
Name: axis_master_fifo

Overview:
- Parametrised AXI-Stream master source stage for the AXI-to-UART path.
- Accepts bytes from a local loader through a valid/ready port and buffers them in a DEPTH-entry FIFO.
- Drives a fully AXI-compliant master port: registered valid/data/last, held stable until ready, with TLAST framing.
- Feeds the downstream AXIS slave/UART TX FIFO. Adds backpressure, occupancy reporting, a packet counter and flush.

Parameters:
- WIDTH, 8: data width in bits for both the load and m_axis ports.
- DEPTH, 16: storage FIFO entries. Must be a power of 2 and at least 2.
- CNT_W, 16: width of the transmitted-packet counter.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- flush  input  1  synchronous clear of storage and the output stage.
- load_data  input  WIDTH  byte to enqueue.
- load_last  input  1  marks the final byte of a packet.
- load_valid  input  1  loader has a byte.
- load_ready  output  1  FIFO can accept a byte.
- m_axis_data  output  WIDTH  TDATA.
- m_axis_last  output  1  TLAST.
- m_axis_valid  output  1  TVALID.
- m_axis_ready  input  1  TREADY from the downstream slave.
- level  output  $clog2(DEPTH)+1  entries in storage, excluding the output register.
- pkt_count  output  CNT_W  packets fully transmitted; wraps modulo 2^CNT_W.

Behaviour:
- Reset (asynchronous, rst high):
  - Pointers, level, pkt_count, m_axis_valid, m_axis_last and m_axis_data all 0.
  - load_ready is 0 while rst is high and 1 on the first cycle after release.
- Storage:
  - Each entry is {last, data}.
  - Read and write pointers are $clog2(DEPTH)+1 bits. Full when the MSBs differ and the rest are equal; empty when all bits are equal.
- Write port:
  - load_ready = !full, purely combinational from registered state.
  - A write occurs when load_valid && load_ready.
  - No same-cycle pass-through: a pop in the same cycle does not unblock a write while full.
- Output stage (single register):
  - Loads from storage when storage is non-empty and either m_axis_valid == 0 or m_axis_valid && m_axis_ready.
  - Latency: a byte written at edge N into an empty FIFO with an idle output drives m_axis_valid = 1 after edge N+1.
  - Total buffering is DEPTH+1 bytes.
- AXI rules:
  - Once m_axis_valid = 1, m_axis_data and m_axis_last hold until the handshake. Valid never drops without a handshake, except on flush or rst.
  - Back-to-back: sustained 1 byte/cycle when the loader and ready are both continuous.
  - m_axis_valid does not depend combinationally on m_axis_ready.
- level:
  - +1 on write, −1 on pop into the output register, unchanged when both happen.
  - Range 0..DEPTH.
- pkt_count: increments on each handshake with m_axis_last = 1.
- flush:
  - Clears pointers, level and m_axis_valid/last on the next edge. m_axis_data and pkt_count are kept.
  - A write presented in the flush cycle is discarded.
  - flush has priority over every other event.

Optional Feature:
- Macro: AXIS_STORE_FWD_EN.
- Defined (store-and-forward):
  - Keeps an internal count of complete packets in storage: +1 on a write with load_last, −1 on a pop with last.
  - The output stage pops only when that count is > 0, or when storage is full (deadlock escape for packets longer than DEPTH).
- Undefined: cut-through. Pop whenever storage is non-empty; the counter logic is absent.

Decomposition:
- Package axis_uart_pkg holds:
  - AXIS_WIDTH_DEF = 8, AXIS_DEPTH_DEF = 16.
  - typedef axis_beat_t {logic last; logic [WIDTH-1:0] data}.
  - The level-width function clog2p1.
- Sub-module axis_sync_fifo: storage array, pointers, full/empty and level.
- The top module adds the output register, pkt_count, flush and the store-and-forward gating.

Test Plan:
- Reset mid-stream:
  - Stimulus: load 0x41,0x42 with m_axis_ready = 0, then assert rst for 1 cycle.
  - Required: valid=0, level=0, pkt_count=0; after release load_ready=1 and m_axis_data=0x00.
- Latency and ordering:
  - Stimulus: with m_axis_ready = 1, load "HELLO\n" (0x48,0x45,0x4C,0x4C,0x4F,0x0A), last on 0x0A.
  - Required: first valid one cycle after the first write; bytes emerge in order; last only on 0x0A; pkt_count=1.
- Backpressure and full:
  - Stimulus: with m_axis_ready = 0, load 0x00..0x10 (17 bytes, DEPTH=16).
  - Required: level=16, load_ready=0, the 18th byte is not accepted, data holds at 0x00.
  - Then ready=1: all 17 bytes drain in order.
- Stability under stalls:
  - Stimulus: toggle m_axis_ready randomly for 100 beats.
  - Required: data/last never change while valid && !ready, and there are no drops or duplicates.
- Flush:
  - Stimulus: with 5 bytes queued, pulse flush.
  - Required: valid=0 and level=0 next cycle; pkt_count unchanged; a subsequent load of 0x55 emerges first.
- Store-and-forward (with AXIS_STORE_FWD_EN):
  - Stimulus: load 3 bytes without last.
  - Required: valid stays 0; after a 4th byte with last, all 4 stream out.
